// File: rtl/crc_calculator_pkg.sv
// Shared CRC-8 constants for the serial CRC calculator.
// Define CRC_ITU_XOR_EN to build the CRC-8/ITU variant (final XOR with 0x55).
package crc_calculator_pkg;

  localparam int         CRC_W    = 8;
  localparam logic [7:0] CRC_POLY = 8'h07;
  localparam logic [7:0] CRC_INIT = 8'h00;

`ifdef CRC_ITU_XOR_EN
  localparam logic [7:0] CRC_XOR_OUT = 8'h55;
`else
  localparam logic [7:0] CRC_XOR_OUT = 8'h00;
`endif

endpackage

// File: rtl/crc8_serial_step.sv
// Combinational one-bit CRC-8 update, MSB-first, non-reflected.
module crc8_serial_step
  import crc_calculator_pkg::*;
(
  input  logic [7:0] crc_in,
  input  logic       bit_in,
  output logic [7:0] crc_out
);

  logic fb;

  assign fb      = crc_in[7] ^ bit_in;
  assign crc_out = {crc_in[6:0], 1'b0} ^ (fb ? CRC_POLY : 8'h00);

endmodule

// File: rtl/crc_calculator.sv
// Serial CRC-8 over data_valid-framed bit streams; registered result per frame.
// Build option: CRC_ITU_XOR_EN selects the CRC-8/ITU output XOR.
module crc_calculator
  import crc_calculator_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       data_in,
  input  logic       data_valid,
  output logic [7:0] crc_out,
  output logic       crc_valid
);

  logic [7:0] crc_work;
  logic [7:0] step_in;
  logic [7:0] step_out;
  logic       vld_prev;
  logic       frame_end;

  // First bit of a frame folds into INIT, never into the last frame's residue.
  assign step_in   = vld_prev ? crc_work : CRC_INIT;
  assign frame_end = vld_prev & ~data_valid;

  crc8_serial_step u_step (
    .crc_in  (step_in),
    .bit_in  (data_in),
    .crc_out (step_out)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      crc_work  <= CRC_INIT;
      crc_out   <= 8'h00;
      crc_valid <= 1'b0;
      vld_prev  <= 1'b0;
    end else begin
      vld_prev  <= data_valid;
      crc_valid <= frame_end;
      if (data_valid)
        crc_work <= step_out;
      if (frame_end)
        crc_out <= crc_work ^ CRC_XOR_OUT;
    end
  end

endmodule

// File: tb/tb_crc_calculator.sv
// Scoreboard bench for crc_calculator: directed spec vectors plus random frames
// checked against a polynomial long-division model.
module tb_crc_calculator;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       data_in;
  logic       data_valid;
  logic [7:0] crc_out;
  logic       crc_valid;

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_q[$];
  logic [7:0] held = 8'h00;
  bit         rst_seen = 1'b0;

`ifdef CRC_ITU_XOR_EN
  localparam logic [7:0] XOR_OUT = 8'h55;
  localparam logic [7:0] EXP_A5 = 8'h27;
  localparam logic [7:0] EXP_3C = 8'hE1;
`else
  localparam logic [7:0] XOR_OUT = 8'h00;
  localparam logic [7:0] EXP_A5 = 8'h72;
  localparam logic [7:0] EXP_3C = 8'hB4;
`endif

  crc_calculator dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .data_in    (data_in),
    .data_valid (data_valid),
    .crc_out    (crc_out),
    .crc_valid  (crc_valid)
  );

  always #5 clk = ~clk;

  // Remainder of M(x)*x^8 divided by x^8+x^2+x+1 (init 0), then output XOR.
  function automatic logic [7:0] ref_crc(input logic [39:0] msg, input int n);
    logic [47:0] r;
    logic [39:0] m;
    m = msg;
    for (int i = n; i < 40; i++) m[i] = 1'b0;
    r = {m, 8'h00};
    for (int i = n + 7; i >= 8; i--)
      if (r[i]) r = r ^ (48'h107 << (i - 8));
    return r[7:0] ^ XOR_OUT;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int k);
    data_valid = 1'b0;
    for (int i = 0; i < k; i++) begin
      data_in = 1'($urandom);
      step();
    end
  endtask

  // Drives n bits MSB-first, then the end cycle; the expectation is queued first.
  task automatic send_frame(input logic [39:0] msg, input int n, input logic [7:0] exp);
    exp_q.push_back(exp);
    for (int i = n - 1; i >= 0; i--) begin
      data_valid = 1'b1;
      data_in    = msg[i];
      step();
    end
    data_valid = 1'b0;
    data_in    = 1'($urandom);
    step();
  endtask

  // Monitor: outputs are sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (!rst_seen) begin
      checks++;
      if (crc_out !== 8'h00 || crc_valid !== 1'b0) begin
        errors++;
        $display("FAIL reset_state: crc_out=%h crc_valid=%b, required 00/0", crc_out, crc_valid);
      end
      held = 8'h00;
    end else if (crc_valid === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pulse: crc_out=%h with no frame pending", crc_out);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (crc_out !== e) begin
          errors++;
          $display("FAIL frame_crc: crc_out=%h, required %h", crc_out, e);
        end
      end
      held = crc_out;
    end else begin
      checks++;
      if (crc_valid !== 1'b0 || crc_out !== held) begin
        errors++;
        $display("FAIL hold: crc_out=%h crc_valid=%b, required %h/0", crc_out, crc_valid, held);
      end
    end
    rst_seen = rst_n;
  end

  initial begin
    int n;
    logic [39:0] msg;
    rst_n      = 1'b0;
    data_valid = 1'b0;
    data_in    = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;
    idle(1);

    send_frame(40'hA5, 8, EXP_A5);
    idle(2);
    send_frame(40'h3C, 8, EXP_3C);
    idle(1);
    send_frame(40'h00, 8, 8'h00 ^ XOR_OUT);
    send_frame(40'hFF, 8, 8'hF3 ^ XOR_OUT);
    idle(2);

    // Reset in the middle of a frame: no pulse, result cleared.
    for (int i = 7; i >= 4; i--) begin
      data_valid = 1'b1;
      data_in    = msg_bit(i);
      step();
    end
    rst_n      = 1'b0;
    data_valid = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;
    idle(1);
    send_frame(40'hA5, 8, EXP_A5);
    idle(3);

    send_frame(40'hA53, 12, ref_crc(40'hA53, 12));
    idle(5);
    send_frame(40'h1, 1, ref_crc(40'h1, 1));
    send_frame(40'h0, 1, ref_crc(40'h0, 1));

    for (int f = 0; f < 30; f++) begin
      n   = $urandom_range(1, 40);
      msg = {8'($urandom), 32'($urandom)};
      send_frame(msg, n, ref_crc(msg, n));
      idle($urandom_range(0, 3));
    end
    idle(4);

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL missing_pulses: %0d frames without crc_valid, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  function automatic logic msg_bit(input int i);
    logic [7:0] b;
    b = 8'hA5;
    return b[i];
  endfunction

endmodule

// File: doc/crc_calculator.md
CRC_CALCULATOR -- requirements
Module: crc_calculator

Interface
- REQ-001 clk  input  1  sole clock; all state updates on rising edge.
- REQ-002 rst_n  input  1  reset; synchronous and active-low, sampled on rising clk.
- REQ-003 data_in  input  1  serial message bit, MSB first; sampled only when data_valid=1.
- REQ-004 data_valid  input  1  bit qualifier; a contiguous run of high cycles is one frame.
- REQ-005 crc_out  output  8  registered CRC of the last completed frame; holds between frames.
- REQ-006 crc_valid  output  1  registered one-cycle pulse marking a new crc_out value.

Function
- REQ-007 Algorithm SHALL be CRC-8: polynomial 0x07, init 0x00, non-reflected, MSB-first.
- REQ-008 Per accepted bit: fb = crc[7] ^ data_in; crc_next = {crc[6:0],1'b0} ^ (fb ? 0x07 : 0x00).
- REQ-009 A frame SHALL start on a data_valid=1 cycle whose previous cycle had data_valid=0 (or reset).
  - The first bit SHALL be folded into INIT (0x00), not into the previous frame's residue.
- REQ-010 Each further data_valid=1 cycle SHALL fold one bit; frame length is unbounded, minimum 1 bit.
- REQ-011 A frame SHALL end on the first data_valid=0 cycle after a high run.
  - On that edge, crc_out <= working CRC (^ XOR_OUT, see REQ-018) and crc_valid <= 1.
  - Latency: crc_valid is high in the cycle after the last bit was sampled, for exactly one cycle.
- REQ-012 crc_out SHALL change only at a frame end and SHALL hold otherwise, including while the next frame is in progress.
- REQ-013 crc_valid SHALL be 0 at all times other than the single cycle defined in REQ-011.
- REQ-014 Back-to-back frames need at least one data_valid=0 cycle between them; that cycle is the end cycle of the earlier frame.
- REQ-015 data_in SHALL be ignored while data_valid=0.

Reset
- REQ-016 While rst_n=0 at a clock edge, the following SHALL all clear to 0, and no crc_valid SHALL follow for any frame in progress:
  - working CRC = 0x00
  - crc_out = 0x00
  - crc_valid = 0
  - previous-valid flag = 0
- REQ-017 After rst_n rises, the first data_valid=1 cycle SHALL start a new frame.

Configuration
- REQ-018 Macro CRC_ITU_XOR_EN:
  - When defined, the final CRC SHALL be XORed with 0x55 before loading crc_out (CRC-8/ITU).
  - When undefined, XOR_OUT = 0x00 (plain CRC-8).
  - The working register is unaffected either way.

Structure
- REQ-019 Package crc_calculator_pkg SHALL hold CRC_POLY=8'h07, CRC_INIT=8'h00 and CRC_XOR_OUT (selected by CRC_ITU_XOR_EN).
- REQ-020 Sub-module crc8_serial_step SHALL implement the combinational one-bit update of REQ-008 (inputs crc_in[7:0], bit; output crc_out[7:0]).
  - The top level holds the registers and frame-edge detection.

Verification (macro undefined unless stated)
- REQ-021 Reset, release, 8 bits of 0xA5 MSB-first with data_valid high for 8 cycles, then low -> one-cycle crc_valid with crc_out=0x72.
- REQ-022 After 2 idle cycles, byte 0x3C -> crc_valid pulse with crc_out=0xB4, proving per-frame re-initialisation; crc_out holds 0x72 during the 0x3C bits.
- REQ-023 Bytes 0x00 -> crc_out=0x00; 0xFF -> crc_out=0xF3; crc_valid pulses exactly once per frame.
- REQ-024 With CRC_ITU_XOR_EN defined: 0xA5 -> 0x27; 0x3C -> 0xE1.
- REQ-025 rst_n=0 asserted after 4 bits of a frame -> crc_out=0x00 and no crc_valid; a subsequent full 0xA5 frame -> 0x72.
- REQ-026 Non-byte frame, 12 bits 0xA53 MSB-first -> crc_out equals the REQ-008 bitwise model result; data_in toggling while data_valid=0 leaves crc_out unchanged.
